// File: rtl/frame_cmd_scheduler.sv
// rtl/frame_cmd_scheduler.sv - host command FIFO streamed onto the sprite command bus, with swaps deferred to vblank
module frame_cmd_scheduler #(
    parameter int FIFO_DEPTH   = 16,
    parameter int VBLANK_START = 480,
    parameter int VCOUNT_MAX   = 524
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic        read,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic [9:0]  vcount,
    output logic [31:0] cmd_out,
    output logic        cmd_valid,
    output logic        fifo_full,
    output logic        swap_pulse
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_WAIT_VBL = 2'd1,
        ST_SWAP     = 2'd2
    } state_t;

    state_t         state;
    logic [31:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           overflow;
    logic           front_buf;
    logic           back_buf;
    logic           swapped_this_frame;

    logic           wr_en;
    logic           rd_en;
    logic           full;
    logic           push;
    logic           pop;
    logic           in_blank;
    logic [31:0]    head;
    logic           head_is_commit;
    logic [31:0]    status;

    assign wr_en          = chipselect & write;
    assign rd_en          = chipselect & read;
    assign full           = (count == CW'(FIFO_DEPTH));
    assign push           = wr_en & ~full;
    assign pop            = (state == ST_RUN) && (count != '0);
    // Lines past the end of the frame count as blanking so a glitching counter cannot stall a swap.
    assign in_blank       = (vcount >= 10'(VBLANK_START)) || (vcount > 10'(VCOUNT_MAX));
    assign head           = mem[rd_ptr];
    assign head_is_commit = (head[20:17] == 4'hF);
    assign status         = {15'b0, overflow, front_buf, state, 13'(count)};
    assign fifo_full      = full;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= writedata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state              <= ST_RUN;
            wr_ptr             <= '0;
            rd_ptr             <= '0;
            count              <= '0;
            overflow           <= 1'b0;
            front_buf          <= 1'b0;
            back_buf           <= 1'b1;
            swapped_this_frame <= 1'b0;
            cmd_out            <= 32'h0;
            cmd_valid          <= 1'b0;
            swap_pulse         <= 1'b0;
            readdata           <= 32'h0;
        end else begin
            cmd_out    <= 32'h0;
            cmd_valid  <= 1'b0;
            swap_pulse <= 1'b0;
            readdata   <= rd_en ? status : 32'h0;

            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase

            // A dropped write in the same cycle as a status read must stay visible.
            if (wr_en && full) begin
                overflow <= 1'b1;
            end else if (rd_en) begin
                overflow <= 1'b0;
            end

            if (!in_blank) begin
                swapped_this_frame <= 1'b0;
            end

            case (state)
                ST_RUN: begin
                    if (pop) begin
                        if (head_is_commit) begin
                            state <= ST_WAIT_VBL;
                        end else begin
                            cmd_out   <= {head[31:14], back_buf, head[12:0]};
                            cmd_valid <= 1'b1;
                        end
                    end
                end
                ST_WAIT_VBL: begin
                    if (in_blank && !swapped_this_frame) begin
                        state      <= ST_SWAP;
                        cmd_out    <= {11'b0, 4'hF, 3'b0, back_buf, 13'b0};
                        cmd_valid  <= 1'b1;
                        swap_pulse <= 1'b1;
                    end
                end
                ST_SWAP: begin
                    front_buf          <= back_buf;
                    back_buf           <= ~back_buf;
                    swapped_this_frame <= 1'b1;
                    state              <= ST_RUN;
                end
                default: begin
                    state <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_cmd_scheduler.sv
// tb/tb_frame_cmd_scheduler.sv - directed and randomized checks of frame_cmd_scheduler against a queue model
module tb_frame_cmd_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        chipselect = 1'b0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [31:0] writedata = 32'h0;
    logic [9:0]  vcount = 10'd100;
    logic [31:0] readdata;
    logic [31:0] cmd_out;
    logic        cmd_valid;
    logic        fifo_full;
    logic        swap_pulse;

    frame_cmd_scheduler #(
        .FIFO_DEPTH(16),
        .VBLANK_START(480),
        .VCOUNT_MAX(524)
    ) dut (
        .clk(clk),
        .reset(reset),
        .chipselect(chipselect),
        .write(write),
        .read(read),
        .writedata(writedata),
        .readdata(readdata),
        .vcount(vcount),
        .cmd_out(cmd_out),
        .cmd_valid(cmd_valid),
        .fifo_full(fifo_full),
        .swap_pulse(swap_pulse)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc_cnt = 0;
    int last_set = 0;

    // Reference model: a plain queue plus a mode (0 streaming, 1 waiting for blanking, 2 swapping).
    logic [31:0] mq[$];
    int          m_mode = 0;
    bit          m_front = 0, m_back = 1, m_swapped = 0, m_ovf = 0, m_live = 0;
    logic [31:0] e_cmd = 0, e_rd = 0;
    bit          e_valid = 0, e_swap = 0, e_full = 0;

    logic [31:0] emits[$];
    int          emit_cyc[$];
    logic [31:0] swaps[$];
    int          swap_cyc[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h time=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        logic [31:0] h;
        int          pre;
        int          old_mode;
        bit          wr, rd;
        cyc_cnt++;
        if (reset) begin
            mq.delete();
            m_mode = 0; m_front = 0; m_back = 1; m_swapped = 0; m_ovf = 0;
            e_cmd = 0; e_valid = 0; e_swap = 0; e_rd = 0;
            m_live = 1;
        end else begin
            wr = chipselect && write;
            rd = chipselect && read;
            pre = mq.size();
            old_mode = m_mode;
            e_cmd = 0; e_valid = 0; e_swap = 0;
            e_rd = rd ? {15'b0, m_ovf, m_front, 2'(m_mode), 8'b0, 5'(pre)} : 32'h0;
            if (rd) m_ovf = 0;
            if (wr && pre == 16) m_ovf = 1;
            if (old_mode != 2 && vcount < 480) m_swapped = 0;
            if (m_mode == 0 && pre > 0) begin
                h = mq.pop_front();
                if (h[20:17] == 4'hF) begin
                    m_mode = 1;
                end else begin
                    e_cmd = h;
                    e_cmd[13] = m_back;
                    e_valid = 1;
                end
            end else if (m_mode == 1) begin
                if (vcount >= 480 && !m_swapped) begin
                    m_mode = 2;
                    e_cmd = 32'h001E0000 | {18'b0, m_back, 13'b0};
                    e_valid = 1;
                    e_swap = 1;
                end
            end else if (m_mode == 2) begin
                m_front = m_back;
                m_back = !m_back;
                m_swapped = 1;
                m_mode = 0;
            end
            if (wr && pre < 16) mq.push_back(writedata);
        end
        e_full = (mq.size() == 16);
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("cmd_out", cmd_out, e_cmd);
            chk("cmd_valid", 32'(cmd_valid), 32'(e_valid));
            chk("swap_pulse", 32'(swap_pulse), 32'(e_swap));
            chk("fifo_full", 32'(fifo_full), 32'(e_full));
            chk("readdata", readdata, e_rd);
            if (cmd_valid === 1'b1 && swap_pulse === 1'b0) begin
                emits.push_back(cmd_out);
                emit_cyc.push_back(cyc_cnt);
            end
            if (swap_pulse === 1'b1) begin
                swaps.push_back(cmd_out);
                swap_cyc.push_back(cyc_cnt);
            end
        end
    end

    task automatic cyc(input bit w, input bit r, input logic [31:0] d);
        @(negedge clk);
        #1;
        chipselect = w | r;
        write = w;
        read = r;
        writedata = d;
        last_set = cyc_cnt;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write = 1'b0;
        read = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0);
    endtask

    task automatic rd_status(output logic [31:0] v);
        cyc(1'b0, 1'b1, 32'h0);
        @(negedge clk);
        v = readdata;
    endtask

    task automatic set_vcount(input int v);
        @(negedge clk);
        #1;
        vcount = 10'(v);
    endtask

    task automatic clear_logs;
        emits.delete(); emit_cyc.delete(); swaps.delete(); swap_cyc.delete();
    endtask

    logic [31:0] t1_in [3] = '{32'h08220001, 32'h08240064, 32'h08260032};
    logic [31:0] t1_exp[3] = '{32'h08222001, 32'h08242064, 32'h08262032};
    int          t1_set[3];

    initial begin
        logic [31:0] st;
        int          s0;
        int          nsw;

        idle(3);
        @(negedge clk);
        chk("reset_readdata", readdata, 32'h0);
        chk("reset_cmd_out", cmd_out, 32'h0);
        chk("reset_cmd_valid", 32'(cmd_valid), 32'h0);
        #1 reset = 1'b0;

        // 1: three commands stream out stamped with back_buf=1
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, t1_in[i]);
            t1_set[i] = last_set;
        end
        idle(4);
        chk("t1_n_emits", 32'(emits.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            chk("t1_value", (i < emits.size()) ? emits[i] : 32'hxxxxxxxx, t1_exp[i]);
            chk("t1_latency", (i < emit_cyc.size()) ? 32'(emit_cyc[i] - t1_set[i]) : 32'hffffffff, 32'd2);
        end
        chk("t1_no_swap", 32'(swaps.size()), 32'd0);

        // 2: commit held until blanking, then swap flips the stamp
        clear_logs();
        cyc(1'b1, 1'b0, 32'h08240010);
        cyc(1'b1, 1'b0, 32'h001E0000);
        idle(6);
        chk("t2_cmd", (emits.size() > 0) ? emits[0] : 32'hxxxxxxxx, 32'h08242010);
        chk("t2_held", 32'(swaps.size()), 32'd0);
        set_vcount(480);
        idle(3);
        chk("t2_n_swaps", 32'(swaps.size()), 32'd1);
        chk("t2_swap_cmd", (swaps.size() > 0) ? swaps[0] : 32'hxxxxxxxx, 32'h001E2000);
        rd_status(st);
        chk("t2_front_buf", 32'(st[15]), 32'd1);
        set_vcount(100);
        clear_logs();
        cyc(1'b1, 1'b0, 32'h08222007);
        idle(3);
        chk("t2_post_swap_cmd", (emits.size() > 0) ? emits[0] : 32'hxxxxxxxx, 32'h08220007);

        // 3: two commits in one blanking interval -> one swap per frame
        clear_logs();
        set_vcount(490);
        cyc(1'b1, 1'b0, 32'h001E0000);
        s0 = last_set;
        cyc(1'b1, 1'b0, 32'h001E0000);
        idle(6);
        chk("t3_first_swap", 32'(swaps.size()), 32'd1);
        chk("t3_swap_within_3", (swap_cyc.size() > 0) ? 32'(swap_cyc[0] - s0 <= 3) : 32'd0, 32'd1);
        chk("t3_swap1_cmd", (swaps.size() > 0) ? swaps[0] : 32'hxxxxxxxx, 32'h001E0000);
        set_vcount(10);
        idle(3);
        chk("t3_second_held", 32'(swaps.size()), 32'd1);
        set_vcount(480);
        idle(4);
        chk("t3_second_swap", 32'(swaps.size()), 32'd2);
        chk("t3_swap2_cmd", (swaps.size() > 1) ? swaps[1] : 32'hxxxxxxxx, 32'h001E2000);

        // 4: fill in WAIT_VBL, overflow on the 17th write, sticky until read
        set_vcount(100);
        cyc(1'b1, 1'b0, 32'h001E0000);
        idle(3);
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 32'h08200000 | 32'(i));
        @(negedge clk);
        chk("t4_full", 32'(fifo_full), 32'd1);
        cyc(1'b1, 1'b0, 32'h08201111);
        rd_status(st);
        chk("t4_ovf_first_read", 32'(st[16]), 32'd1);
        chk("t4_count", 32'(st[4:0]), 32'd16);
        chk("t4_state_wait", 32'(st[14:13]), 32'd1);
        rd_status(st);
        chk("t4_ovf_second_read", 32'(st[16]), 32'd0);

        // 5: write to full FIFO on the first RUN pop cycle is dropped
        set_vcount(480);
        cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0820ABCD);
        rd_status(st);
        chk("t5_ovf", 32'(st[16]), 32'd1);
        chk("t5_count", 32'(st[4:0]), 32'd15);
        set_vcount(100);
        idle(20);

        // 6: reset in WAIT_VBL with 5 queued discards everything
        cyc(1'b1, 1'b0, 32'h001E0000);
        idle(3);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 32'h08300000 | 32'(i));
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("t6_valid", 32'(cmd_valid), 32'd0);
        chk("t6_cmd_out", cmd_out, 32'h0);
        #1 reset = 1'b0;
        rd_status(st);
        chk("t6_count", 32'(st[4:0]), 32'd0);
        chk("t6_front", 32'(st[15]), 32'd0);
        clear_logs();
        set_vcount(480);
        idle(8);
        chk("t6_no_swap", 32'(swaps.size()), 32'd0);

        // Random traffic across sweeping frames
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            #1;
            reset = ($urandom_range(0, 599) == 0);
            chipselect = ($urandom_range(0, 7) != 0);
            write = ($urandom_range(0, 1) == 1);
            read = ($urandom_range(0, 7) == 0);
            writedata = $urandom;
            if ($urandom_range(0, 5) == 0) writedata[20:17] = 4'hF;
            nsw = int'(vcount) + $urandom_range(0, 24);
            vcount = 10'(nsw % 540);
        end
        @(negedge clk);
        #1;
        reset = 1'b0; chipselect = 1'b0; write = 1'b0; read = 1'b0;
        idle(25);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
